gray_sync_decoder: RTL and testbench

- Downstream consumer of the binary-to-Gray encoder stage.
- Receives a Gray-coded count, typically launched from another clock domain, and passes it through a multi-flop synchroniser.
- Decodes it back to binary (registered) and emits a one-cycle valid pulse on each value change, with count direction.
- Flags any illegal multi-bit Gray transition in a sticky error bit.

---
 rtl/gray_sync_decoder_pkg.sv | 34 +++
 rtl/gray_sync_decoder_chain.sv | 44 ++++
 rtl/gray_sync_decoder.sv | 131 +++++++++++++
 tb/tb_gray_sync_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gray_sync_decoder_pkg.sv
// gray_sync_decoder_pkg
//   Shared helpers for the Gray-code pipeline: the default counter width used
//   by the encoder stage, plus Gray-to-binary decode and popcount.
//
//   The functions work on a fixed GSD_MAX_W-bit vector. Callers zero-extend
//   their N-bit value into it. Zero upper bits do not change either result:
//   each gray2bin output bit is the XOR of the input bits at and above it, and
//   popcount counts only ones. This lets every width N <= GSD_MAX_W share one
//   function body.
package gray_sync_decoder_pkg;

  localparam int GSD_DEFAULT_N = 4;
  localparam int GSD_MAX_W     = 32;

  // b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i]
  function automatic logic [GSD_MAX_W-1:0] gray2bin(input logic [GSD_MAX_W-1:0] g);
    logic [GSD_MAX_W-1:0] b;
    b[GSD_MAX_W-1] = g[GSD_MAX_W-1];
    for (int i = GSD_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [GSD_MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < GSD_MAX_W; i++) begin
      c = c + {31'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/gray_sync_decoder_chain.sv
// gray_sync_chain
//   Plain multi-flop synchroniser for an N-bit Gray bus. Nothing sits between
//   the flops, so CDC constraints and lint waivers can target this module alone.
//
//   Ports:
//     clk    - destination clock
//     rst_n  - asynchronous active-low reset; every stage clears to 0
//     d_in   - Gray value, possibly asynchronous to clk
//     d_out  - synchronised value from the last stage
module gray_sync_chain #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d_in,
  output logic [N-1:0] d_out
);

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      logic [N-1:0] d;
      logic [N-1:0] q;

      if (gi == 0) begin : g_first
        assign d = d_in;
      end else begin : g_rest
        assign d = g_stage[gi-1].q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else begin
          q <= d;
        end
      end
    end
  endgenerate

  assign d_out = g_stage[SYNC_STAGES-1].q;

endmodule

// File: rtl/gray_sync_decoder.sv
// gray_sync_decoder
//   Receives a Gray-coded count, synchronises it into clk, and decodes it to
//   a registered binary value. Each change of the value produces a one-cycle
//   valid pulse that reports the step direction and whether the step was
//   exactly +/-1. Any transition that flips more than one Gray bit sets a
//   sticky error flag.
//
//   Ports:
//     clk            - single clock for all state
//     rst_n          - asynchronous active-low reset
//     gray_in        - Gray-coded input, may be asynchronous to clk
//     err_clr        - clears multi_bit_err (a new error in the same cycle wins)
//     bin_out        - registered binary decode of the synchronised value
//     bin_valid      - one-cycle pulse: bin_out holds a new value
//     dir_up         - with bin_valid: 1 = +1 step, 0 = -1 step or jump
//     step_ok        - with bin_valid: 1 = step was exactly +/-1 mod 2^N
//     multi_bit_err  - sticky multi-bit transition flag
module gray_sync_decoder
  import gray_sync_decoder_pkg::*;
#(
  parameter int N           = GSD_DEFAULT_N,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] gray_in,
  input  logic         err_clr,
  output logic [N-1:0] bin_out,
  output logic         bin_valid,
  output logic         dir_up,
  output logic         step_ok,
  output logic         multi_bit_err
);

  // Priming lasts until the first real synchronised sample has also reached
  // g_prev. That takes SYNC_STAGES edges to fill the chain plus one more edge.
  localparam int             PW        = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0]  PRIME_MAX = PW'(SYNC_STAGES + 1);

  logic [N-1:0]           g_sync;
  logic [N-1:0]           g_prev_reg;
  logic [PW-1:0]          prime_cnt_reg;
  logic [N-1:0]           d;
  logic [N-1:0]           bin_new;
  logic [N-1:0]           bin_plus1;
  logic [N-1:0]           bin_minus1;
  logic [GSD_MAX_W-1:0]   bin_new_ext;
  logic [GSD_MAX_W-N-1:0] unused_bin_hi;
  logic                   primed;
  logic                   changed;
  logic                   multi_flip;

  gray_sync_chain #(
    .N           (N),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_chain (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (gray_in),
    .d_out (g_sync)
  );

  // Decode. The upper bits of the widened result are always zero.
  assign bin_new_ext   = gray2bin(GSD_MAX_W'(g_sync));
  assign bin_new       = bin_new_ext[N-1:0];
  assign unused_bin_hi = bin_new_ext[GSD_MAX_W-1:N];

  assign d          = g_sync ^ g_prev_reg;
  assign changed    = |d;
  assign multi_flip = popcount(GSD_MAX_W'(d)) > 1;
  assign primed     = (prime_cnt_reg == PRIME_MAX);

  // bin_out always holds gray2bin(g_prev), so it is the "old" value here.
  assign bin_plus1  = bin_out + N'(1);
  assign bin_minus1 = bin_out - N'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_cnt_reg <= '0;
    end else if (!primed) begin
      prime_cnt_reg <= prime_cnt_reg + PW'(1);
    end
  end

  // Decode and history registers track every cycle, including while priming,
  // so the first real value becomes the baseline without a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_prev_reg <= '0;
      bin_out    <= '0;
    end else begin
      g_prev_reg <= g_sync;
      bin_out    <= bin_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_valid <= 1'b0;
      dir_up    <= 1'b0;
      step_ok   <= 1'b0;
    end else begin
      bin_valid <= primed && changed;
      // dir_up and step_ok keep their last values between pulses.
      if (primed && changed) begin
        if (bin_new == bin_plus1) begin
          dir_up  <= 1'b1;
          step_ok <= 1'b1;
        end else if (bin_new == bin_minus1) begin
          dir_up  <= 1'b0;
          step_ok <= 1'b1;
        end else begin
          dir_up  <= 1'b0;
          step_ok <= 1'b0;
        end
      end
    end
  end

  // A new error takes priority over err_clr in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_bit_err <= 1'b0;
    end else if (primed && multi_flip) begin
      multi_bit_err <= 1'b1;
    end else if (err_clr) begin
      multi_bit_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_sync_decoder.sv
// tb_gray_sync_decoder
//   Directed-vector bench for gray_sync_decoder (N=4, SYNC_STAGES=2).
//   Inputs change 1 time unit after a rising edge. Outputs are sampled at the
//   same point. Valid pulses are counted on the falling edge.
module tb_gray_sync_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       err_clr;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       dir_up;
  logic       step_ok;
  logic       multi_bit_err;

  int         tests_run;
  int         tests_failed;
  int         pulse_total;
  logic [3:0] cur_bin;

  gray_sync_decoder #(
    .N           (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .gray_in       (gray_in),
    .err_clr       (err_clr),
    .bin_out       (bin_out),
    .bin_valid     (bin_valid),
    .dir_up        (dir_up),
    .step_ok       (step_ok),
    .multi_bit_err (multi_bit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial pulse_total = 0;
  always @(negedge clk) begin
    if (bin_valid === 1'b1) pulse_total++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one Gray value and follow it through the 3-edge latency.
  task automatic step(input string tag, input logic [3:0] g, input logic [3:0] exp_bin,
                      input logic exp_dir, input logic exp_ok);
    int p0;
    p0 = pulse_total;
    gray_in = g;
    tick();
    tick();
    check({tag, " hold"}, 32'(bin_out), 32'(cur_bin));
    check({tag, " no_early_valid"}, 32'(bin_valid), 32'd0);
    tick();
    check({tag, " bin"}, 32'(bin_out), 32'(exp_bin));
    check({tag, " valid"}, 32'(bin_valid), 32'd1);
    check({tag, " dir"}, 32'(dir_up), 32'(exp_dir));
    check({tag, " step_ok"}, 32'(step_ok), 32'(exp_ok));
    tick();
    check({tag, " valid_drop"}, 32'(bin_valid), 32'd0);
    check({tag, " one_pulse"}, 32'(pulse_total - p0), 32'd1);
    cur_bin = exp_bin;
  endtask

  task automatic do_reset(input logic [3:0] g, input logic [3:0] b);
    gray_in = g;
    err_clr = 1'b0;
    rst_n   = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    cur_bin = b;
  endtask

  // Triangle count 0,1..15,14..1,0,1..
  function automatic int tri_v(input int k);
    int p;
    p = k % 30;
    return (p <= 15) ? p : 30 - p;
  endfunction

  initial begin
    int p0;
    logic [3:0] v;
    tests_run    = 0;
    tests_failed = 0;
    rst_n   = 1'b0;
    gray_in = 4'b0110;
    err_clr = 1'b0;
    cur_bin = 4'd0;

    // 1: reset values, then silent priming onto gray 0110 (bin 4)
    repeat (2) tick();
    check("t1 rst bin_out", 32'(bin_out), 32'd0);
    check("t1 rst valid", 32'(bin_valid), 32'd0);
    check("t1 rst dir", 32'(dir_up), 32'd0);
    check("t1 rst step_ok", 32'(step_ok), 32'd0);
    check("t1 rst err", 32'(multi_bit_err), 32'd0);
    p0 = pulse_total;
    rst_n = 1'b1;
    repeat (6) tick();
    check("t1 primed bin", 32'(bin_out), 32'd4);
    check("t1 no pulse", 32'(pulse_total - p0), 32'd0);
    check("t1 err", 32'(multi_bit_err), 32'd0);
    cur_bin = 4'd4;

    // 2: unit steps down to 3, then back up to 4
    step("t2 down", 4'b0010, 4'd3, 1'b0, 1'b1);
    step("t2 up", 4'b0110, 4'd4, 1'b1, 1'b1);

    // 3: wrap 15 -> 0 is up, 0 -> 15 is down
    do_reset(4'b1000, 4'd15);
    step("t3 wrap up", 4'b0000, 4'd0, 1'b1, 1'b1);
    step("t3 wrap down", 4'b1000, 4'd15, 1'b0, 1'b1);
    check("t3 err", 32'(multi_bit_err), 32'd0);

    // 4: two-bit jump, sticky error, clear, then set-beats-clear
    do_reset(4'b0000, 4'd0);
    step("t4 jump", 4'b0011, 4'd2, 1'b0, 1'b0);
    check("t4 err set", 32'(multi_bit_err), 32'd1);
    repeat (3) tick();
    check("t4 err sticky", 32'(multi_bit_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4 err cleared", 32'(multi_bit_err), 32'd0);
    gray_in = 4'b0000;
    err_clr = 1'b1;
    repeat (3) tick();
    check("t4 clr jump bin", 32'(bin_out), 32'd0);
    check("t4 clr jump valid", 32'(bin_valid), 32'd1);
    check("t4 clr jump step_ok", 32'(step_ok), 32'd0);
    check("t4 set wins", 32'(multi_bit_err), 32'd1);
    err_clr = 1'b0;
    tick();
    check("t4 err held", 32'(multi_bit_err), 32'd1);

    // 5: free-running triangle count; bin_out lags the source by 2 samples
    do_reset(4'b0000, 4'd0);
    for (int i = 0; i < 100; i++) begin
      v = 4'(tri_v(i + 1));
      gray_in = v ^ (v >> 1);
      tick();
      if (i >= 2) begin
        check($sformatf("t5 bin[%0d]", i), 32'(bin_out), 32'(tri_v(i - 1)));
        check($sformatf("t5 valid[%0d]", i), 32'(bin_valid), 32'd1);
        check($sformatf("t5 step_ok[%0d]", i), 32'(step_ok), 32'd1);
        check($sformatf("t5 dir[%0d]", i), 32'(dir_up),
              32'(tri_v(i - 1) > tri_v(i - 2)));
      end
    end
    check("t5 err", 32'(multi_bit_err), 32'd0);

    // 6: asynchronous reset mid-count, then re-prime on gray 0101 (bin 6)
    #2;
    rst_n   = 1'b0;
    gray_in = 4'b0101;
    #1;
    check("t6 async bin", 32'(bin_out), 32'd0);
    check("t6 async valid", 32'(bin_valid), 32'd0);
    check("t6 async dir", 32'(dir_up), 32'd0);
    check("t6 async step_ok", 32'(step_ok), 32'd0);
    check("t6 async err", 32'(multi_bit_err), 32'd0);
    tick();
    rst_n = 1'b1;
    p0 = pulse_total;
    repeat (4) tick();
    check("t6 no pulse priming", 32'(pulse_total - p0), 32'd0);
    check("t6 baseline", 32'(bin_out), 32'd6);
    cur_bin = 4'd6;
    step("t6 resume", 4'b0111, 4'd5, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
